// File: rtl/ref_level_sched_pkg.sv
// Shared constants, state encoding and helpers for the reference-level scheduler.
package ref_level_sched_pkg;

  localparam int unsigned LFSR_LEN     = 8;
  localparam int unsigned WIN_LOG2_DEF = LFSR_LEN;
  localparam int unsigned LOCK_TOL_DEF = 64;
  localparam int unsigned LOCK_CNT_DEF = 4;
  localparam int unsigned SAMPLE_W     = 18;
  localparam int unsigned DIFF_W       = SAMPLE_W + 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StAccum   = 3'd2,
    StWaitRef = 3'd3,
    StWaitPwr = 3'd4,
    StUpdate  = 3'd5
  } sched_state_e;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // |a - b| evaluated one bit wider than the samples so full-scale swings cannot wrap.
  function automatic logic [DIFF_W-1:0] abs_diff(input sample_t a, input sample_t b);
    logic signed [DIFF_W-1:0] d;
    d = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
    return d[DIFF_W-1] ? DIFF_W'(-d) : DIFF_W'(d);
  endfunction

endpackage

// File: rtl/ref_level_sched_lock_det.sv
// Window-to-window convergence detector: counts consecutive stable reference updates.
module ref_lock_det
  import ref_level_sched_pkg::*;
#(
  parameter int unsigned LOCK_TOL = LOCK_TOL_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t ref_new,
  input  sample_t ref_prev,
  input  logic    update,
  input  logic    clear,
  output logic    locked
);

  localparam int unsigned STAB_W = cnt_w(LOCK_CNT);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_CNT);

  logic [DIFF_W-1:0] diff_abs;
  logic              stable;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              first_win_q, first_win_d;
  logic              locked_q, locked_d;

  assign diff_abs = abs_diff(ref_new, ref_prev);
  assign stable   = (diff_abs <= DIFF_W'(LOCK_TOL));

  always_comb begin
    stab_cnt_d  = stab_cnt_q;
    first_win_d = first_win_q;
    locked_d    = locked_q;
    if (clear) begin
      stab_cnt_d  = '0;
      first_win_d = 1'b1;
      locked_d    = 1'b0;
    end else if (update) begin
      first_win_d = 1'b0;
      if (first_win_q) begin
        // No previous window to compare against yet.
        stab_cnt_d = '0;
        locked_d   = 1'b0;
      end else if (stable) begin
        if (stab_cnt_q < STAB_MAX) begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
        locked_d = (stab_cnt_d == STAB_MAX);
      end else begin
        stab_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stab_cnt_q  <= '0;
      first_win_q <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      stab_cnt_q  <= stab_cnt_d;
      first_win_q <= first_win_d;
      locked_q    <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/ref_level_sched.sv
// Sequences accumulator windows, captures settled reference level / average power, tracks lock.
module ref_level_sched
  import ref_level_sched_pkg::*;
#(
  parameter int unsigned WIN_LOG2  = WIN_LOG2_DEF,
  parameter int unsigned POWER_LAT = 2,
  parameter int unsigned LOCK_TOL  = LOCK_TOL_DEF,
  parameter int unsigned LOCK_CNT  = LOCK_CNT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic                       start,
  input  logic                       cont_mode,
  input  logic                       abort,
  input  logic signed [SAMPLE_W-1:0] ref_in,
  input  logic signed [SAMPLE_W-1:0] pwr_in,
  output logic                       acc_clr,
  output logic                       busy,
  output logic signed [SAMPLE_W-1:0] ref_level,
  output logic signed [SAMPLE_W-1:0] avg_power,
  output logic                       upd_valid,
  output logic                       locked
);

  localparam int unsigned LAT_W = cnt_w(POWER_LAT);
  localparam logic [WIN_LOG2-1:0] SYM_LAST = '1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((POWER_LAT == 0) ? 0 : POWER_LAT - 1);

  sched_state_e      state_q, state_d;
  logic [WIN_LOG2-1:0] sym_cnt_q, sym_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  sample_t           ref_prev_q, ref_prev_d;
  sample_t           ref_level_q, ref_level_d;
  sample_t           avg_power_q, avg_power_d;
  logic              acc_clr_q, acc_clr_d;
  logic              busy_q, busy_d;
  logic              upd_valid_q, upd_valid_d;
  logic              do_update;
  logic              lock_clear;

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    ref_prev_d  = ref_prev_q;
    ref_level_d = ref_level_q;
    avg_power_d = avg_power_q;
    upd_valid_d = 1'b0;
    do_update   = 1'b0;
    lock_clear  = 1'b0;
    if (abort) begin
      // Held outputs survive an abort; only the sequencing and lock history are dropped.
      state_d    = StIdle;
      lock_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StClear;
        end
        StClear: begin
          sym_cnt_d = '0;
          state_d   = StAccum;
        end
        StAccum: begin
          if (clk_en) begin
            sym_cnt_d = sym_cnt_q + 1'b1;
            if (sym_cnt_q == SYM_LAST) state_d = StWaitRef;
          end
        end
        StWaitRef: begin
          if (clk_en) begin
            lat_cnt_d = '0;
            state_d   = (POWER_LAT == 0) ? StUpdate : StWaitPwr;
          end
        end
        StWaitPwr: begin
          lat_cnt_d = lat_cnt_q + 1'b1;
          if (lat_cnt_q == LAT_LAST) state_d = StUpdate;
        end
        StUpdate: begin
          ref_level_d = ref_in;
          avg_power_d = pwr_in;
          ref_prev_d  = ref_in;
          upd_valid_d = 1'b1;
          do_update   = 1'b1;
          state_d     = cont_mode ? StClear : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs come straight from flops so acc_clr cannot glitch.
  assign acc_clr_d = (state_d == StClear) || (abort && (state_q != StIdle));
  assign busy_d    = (state_d != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sym_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      ref_prev_q  <= '0;
      ref_level_q <= '0;
      avg_power_q <= '0;
      acc_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      upd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      ref_prev_q  <= ref_prev_d;
      ref_level_q <= ref_level_d;
      avg_power_q <= avg_power_d;
      acc_clr_q   <= acc_clr_d;
      busy_q      <= busy_d;
      upd_valid_q <= upd_valid_d;
    end
  end

  ref_lock_det #(
    .LOCK_TOL (LOCK_TOL),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock_det (
    .clk      (clk),
    .reset    (reset),
    .ref_new  (ref_in),
    .ref_prev (ref_prev_q),
    .update   (do_update),
    .clear    (lock_clear),
    .locked   (locked)
  );

  assign acc_clr   = acc_clr_q;
  assign busy      = busy_q;
  assign ref_level = ref_level_q;
  assign avg_power = avg_power_q;
  assign upd_valid = upd_valid_q;

endmodule
